// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding, frame
// constants and the parity helper.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        LINE_IDLE = 1'b1;
  localparam logic        START_BIT = 1'b0;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

  // Even parity = XOR of the data bits; odd parity is its complement.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Free-running bit-period counter. Counts 0..CLKS_PER_BIT-1 and flags the
// terminal count; clr forces the count back to 0.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q;

  // Count up, wrapping at the terminal count or restarting on clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr || (cnt_q == CntMax)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: one frame per accepted byte (start, 8 data bits
// LSB-first, optional parity, one stop bit).
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       parity_en,
  input  logic       parity_odd,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

  tx_state_e      state_q;
  logic [7:0]     data_q;
  logic           par_en_q;
  logic           par_odd_q;
  logic [2:0]     bit_idx_q;
  logic [2:0]     bit_idx_nxt;
  logic           tick;
  logic           baud_clr;

  // Hold the bit timer at zero while idle so every frame starts on a fresh period.
  assign baud_clr    = (state_q == StIdle);
  assign bit_idx_nxt = bit_idx_q + 3'd1;
  assign tx_ready    = (state_q == StIdle);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk (clk),
    .rst (rst),
    .clr (baud_clr),
    .tick(tick)
  );

  // Frame sequencer; tx/busy/done are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      bit_idx_q <= '0;
      tx        <= LINE_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tx_valid) begin
            data_q    <= tx_data;
            par_en_q  <= parity_en;
            par_odd_q <= parity_odd;
            bit_idx_q <= '0;
            state_q   <= StStart;
            tx        <= START_BIT;
            busy      <= 1'b1;
          end
        end
        StStart: begin
          if (tick) begin
            state_q   <= StData;
            bit_idx_q <= '0;
            tx        <= data_q[0];
          end
        end
        StData: begin
          if (tick) begin
            if (bit_idx_q != LastBit) begin
              bit_idx_q <= bit_idx_nxt;
              tx        <= data_q[bit_idx_nxt];
            end else if (par_en_q) begin
              state_q <= StParity;
              tx      <= parity_bit(data_q, par_odd_q);
            end else begin
              state_q <= StStop;
              tx      <= LINE_IDLE;
            end
          end
        end
        StParity: begin
          if (tick) begin
            state_q <= StStop;
            tx      <= LINE_IDLE;
          end
        end
        StStop: begin
          if (tick) begin
            state_q <= StIdle;
            tx      <= LINE_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          tx      <= LINE_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a queue-based frame model checked every cycle, plus
// literal expectations on captured frames and done timing.
module tb_uart_tx_ctrl;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       parity_en;
  logic       parity_odd;
  logic       tx;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  uart_tx_ctrl #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the expected line level for each remaining cycle of the current frame.
  bit exp_q[$];
  bit done_pend;

  function automatic void push_frame(input logic [7:0] d, input logic pen, input logic podd);
    int ones;
    bit par;
    ones = $countones(d);
    // Parity bit chosen so the total number of ones is even (or odd).
    par  = podd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    for (int c = 0; c < int'(CPB); c++) exp_q.push_back(1'b0);
    for (int b = 0; b < 8; b++)
      for (int c = 0; c < int'(CPB); c++) exp_q.push_back(d[b]);
    if (pen)
      for (int c = 0; c < int'(CPB); c++) exp_q.push_back(par);
    for (int c = 0; c < int'(CPB); c++) exp_q.push_back(1'b1);
  endfunction

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      done_pend = 1'b0;
    end else if (exp_q.size() > 0) begin
      check("tx", 32'(tx), 32'(exp_q[0]));
      check("busy", 32'(busy), 32'd1);
      check("tx_ready", 32'(tx_ready), 32'd0);
      check("done", 32'(done), 32'd0);
      void'(exp_q.pop_front());
      done_pend = (exp_q.size() == 0);
    end else begin
      check("idle_tx", 32'(tx), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_ready", 32'(tx_ready), 32'd1);
      check("idle_done", 32'(done), 32'(done_pend));
      done_pend = 1'b0;
      if (tx_valid) push_frame(tx_data, parity_en, parity_odd);
    end
  end

  // Wait (bounded) for the falling-edge sample where the byte will be accepted.
  task automatic wait_accept(output bit ok);
    int guard;
    guard = 0;
    ok    = 1'b0;
    while (guard < 200 && !ok) begin
      @(negedge clk);
      guard++;
      ok = tx_ready && tx_valid;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Send one byte; capture the mid-bit line values and the done offset
  // (cycles after the acceptance cycle).
  task automatic run_frame(input logic [7:0] d, input logic pen, input logic podd,
                           input bit mess, output logic [10:0] bits, output int done_off);
    bit ok;
    @(posedge clk);
    #1;
    tx_data    = d;
    parity_en  = pen;
    parity_odd = podd;
    tx_valid   = 1'b1;
    bits       = '1;
    done_off   = -1;
    wait_accept(ok);
    if (!ok) return;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    for (int off = 1; off <= 60; off++) begin
      @(negedge clk);
      if (((off - 1) % CPB) == 1 && ((off - 1) / CPB) < 11) bits[(off-1)/CPB] = tx;
      if (done) begin
        done_off = off;
        break;
      end
      if (mess && off == 10) begin
        #1;
        tx_data    = ~d;
        parity_en  = ~pen;
        parity_odd = ~podd;
      end
    end
  endtask

  logic [10:0] bits;
  int          doff;
  int          gap;
  bit          ok;

  initial begin
    rst        = 1'b1;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("idle20_tx", 32'(tx), 32'd1);
    check("idle20_ready", 32'(tx_ready), 32'd1);

    // 0xA5, even parity: 0 | 1,0,1,0,0,1,0,1 | 0 | 1
    run_frame(8'hA5, 1'b1, 1'b0, 1'b0, bits, doff);
    check("a5_frame", 32'(bits), 32'(11'b10101001010));
    check("a5_done_off", 32'(doff), 32'd45);

    run_frame(8'h07, 1'b1, 1'b1, 1'b0, bits, doff);
    check("07_odd_par", 32'(bits[9]), 32'd0);
    check("07_odd_stop", 32'(bits[10]), 32'd1);
    run_frame(8'h07, 1'b1, 1'b0, 1'b0, bits, doff);
    check("07_even_par", 32'(bits[9]), 32'd1);

    // 0x00 without parity, with inputs disturbed mid-frame.
    run_frame(8'h00, 1'b0, 1'b0, 1'b1, bits, doff);
    check("00_frame", 32'(bits[9:0]), 32'(10'b1000000000));
    check("00_done_off", 32'(doff), 32'd41);

    // Back-to-back: valid held high across two frames.
    @(posedge clk);
    #1;
    tx_data   = 8'h3C;
    parity_en = 1'b0;
    tx_valid  = 1'b1;
    wait_accept(ok);
    @(posedge clk);
    #1;
    tx_data = 8'hC3;
    gap     = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!tx_ready && gap < 200);
    check("b2b_gap", 32'(gap), 32'd41);
    check("b2b_done", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (45) @(posedge clk);

    // Reset during data bit 3 of 0xFF.
    @(posedge clk);
    #1;
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    wait_accept(ok);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (18) @(negedge clk);
    check("ff_busy_before", 32'(busy), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(tx_ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);

    run_frame(8'h55, 1'b0, 1'b0, 1'b0, bits, doff);
    check("55_frame", 32'(bits[9:0]), 32'(10'b1010101010));
    check("55_done_off", 32'(doff), 32'd41);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller that sequences one serial frame per accepted byte: start bit, 8 data bits LSB-first, optional parity bit, one stop bit. It owns bit timing through an internal baud counter, latches the byte and the parity mode at acceptance, and computes even or odd parity over the latched byte. It sits between the byte-producing logic upstream (valid/ready handshake) and the `tx` pin.

## Interface

- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range ≥ 2
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- tx_data  input  8  byte to send; sampled on acceptance
- tx_valid  input  1  upstream has a byte
- tx_ready  output  1  controller can accept; equals (state == IDLE)
- parity_en  input  1  1 = insert parity bit; sampled on acceptance
- parity_odd  input  1  0 = even parity, 1 = odd; sampled on acceptance
- tx  output  1  serial line, idle high
- busy  output  1  frame in progress (state ≠ IDLE)
- done  output  1  one-cycle pulse at frame completion

## Operation

- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance: the rising edge where `tx_valid && tx_ready`.
  - Latches `tx_data`, `parity_en` and `parity_odd`.
  - Clears the baud and bit counters.
  - Next state is START.
- Parity is computed from the latched byte: even parity bit = ^data; odd parity bit = ~^data. Even parity makes the total count of ones (data + parity) even.
- Line value per state:
  - IDLE = 1
  - START = 0
  - DATA = data[bit_idx], with bit_idx 0..7
  - PARITY = parity bit
  - STOP = 1
- Each state holds for exactly CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1, and the state advances when it reaches the terminal count.
- Transitions:
  - START → DATA.
  - DATA → DATA while bit_idx < 7, with bit_idx incrementing.
  - DATA → PARITY if the latched parity_en = 1, else DATA → STOP.
  - PARITY → STOP.
  - STOP → IDLE.
- The STOP → IDLE transition asserts `done` for exactly one cycle, the first cycle in IDLE.
- Inputs changing mid-frame have no effect on the frame.
- `tx_valid` asserted while busy is neither queued nor dropped. It simply waits, because `tx_ready` is 0.
- Back-to-back frames: if `tx_valid` is high in the cycle `done` is high, the next byte is accepted on that edge. The line then sees exactly one idle-high cycle between the stop bit and the next start bit.

## Timing

- Reset values: tx = 1, busy = 0, done = 0, state = IDLE (so tx_ready = 1), counters = 0, latched data = 0.
- Reset mid-frame aborts immediately:
  - tx returns to 1 asynchronously.
  - No done pulse is generated.
  - The first acceptance after reset release starts a clean frame.
- `tx` and `busy` are registered. `tx_ready` is decoded from the state register only, with no combinational path from `tx_valid`.
- Start bit appears on `tx` in the first cycle after acceptance.
- Frame length from the first start-bit cycle to the first IDLE cycle is (10 + parity_en) × CLKS_PER_BIT cycles: 40 or 44 at CLKS_PER_BIT = 4.
- `done` is asserted (10 + parity_en) × CLKS_PER_BIT + 1 cycles after the acceptance edge.

## Structure

- The shared package `uart_pkg` holds:
  - the state encoding: IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4, in 3 bits
  - DATA_BITS = 8
  - the line-level constants LINE_IDLE = 1 and START_BIT = 0
- One sub-module is natural: `uart_baud_cnt`.
  - Parameter CLKS_PER_BIT.
  - Inputs clk, rst, clr; output tick.
  - `tick` is high on the terminal count. `clr` restarts the count from 0.
- The FSM, bit index, shift/select logic and parity logic stay in `uart_tx_ctrl`.

## Test plan

All scenarios use CLKS_PER_BIT = 4.

- Reset → tx = 1, tx_ready = 1, busy = 0, done = 0. Hold tx_valid = 0 for 20 cycles → no change.
- tx_data = 0xA5, parity_en = 1, parity_odd = 0 → tx sequence 0 | 1,0,1,0,0,1,0,1 | 0 | 1, each bit 4 cycles; done fires 45 cycles after acceptance.
- tx_data = 0x07, parity_en = 1, parity_odd = 1 → parity bit = 0. Repeat with parity_odd = 0 → parity bit = 1.
- tx_data = 0x00, parity_en = 0 → 0 | eight 0s | 1, 40-cycle frame. Toggling parity_en and tx_data mid-frame leaves the frame unchanged.
- tx_valid held high with 0x3C then 0xC3 → two frames with exactly one idle cycle between them; tx_ready stays low throughout each frame.
- Assert rst during data bit 3 of 0xFF → tx = 1 immediately, busy = 0, no done. After release, 0x55 is sent correctly.
